mux8_rr_arbiter: RTL
====================

# mux8_rr_arbiter

Round-robin scheduler that shares the 8:1 behavioural multiplexer among eight requesters. It samples an 8-bit request vector, grants exactly one requester at a time, and drives the mux select lines S2/S1/S0 so that the granted requester's data input (A..H) appears on Z. A grant is held until the owner releases it or a hold timeout expires, and priority then rotates so that no requester starves.

## Interface
Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held; 0 disables the timeout. Legal range is 0..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- REQ  input  8  request vector; bit i requests the mux input at index i (0=A .. 7=H).
- DONE  input  1  owner release strobe; sampled only while a grant is active.
- GNT  output  8  one-hot grant, registered; all-zero when idle.
- S2  output  1  mux select MSB, registered.
- S1  output  1  mux select, registered.
- S0  output  1  mux select LSB, registered.
- VALID  output  1  high while GNT is non-zero; Z is meaningful only when this is high.
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 3-bit priority pointer PTR.
  - 3-bit owner index OWN.
  - 8-bit hold counter HCNT.
- IDLE:
  - If REQ is non-zero, select the first set bit at or after PTR, searching upward and wrapping 7 to 0.
  - Load OWN with that index, set GNT to one-hot(OWN), set {S2,S1,S0} to OWN, set VALID=1, clear HCNT, and go to GRANT.
  - If REQ is zero, all outputs stay as they are. GNT and VALID are 0. S2..S0 hold their last value.
- GRANT:
  - HCNT increments every cycle, saturating at 255.
  - Release happens when any of these is true:
    - DONE=1;
    - REQ[OWN]=0;
    - MAX_HOLD≠0 and HCNT = MAX_HOLD-1.
  - On release: GNT goes to 0, VALID goes to 0, PTR becomes OWN+1 mod 8, and the FSM returns to IDLE.
  - TIMEOUT pulses only when the timeout is the sole release cause. If DONE or a dropped request coincides with the timeout, the release is normal and TIMEOUT stays 0.
- Requests from non-owners during GRANT are ignored and do not preempt the owner.
- DONE sampled in IDLE is ignored.
- Invariants:
  - GNT is always zero or one-hot.
  - When VALID=1, GNT = one-hot({S2,S1,S0}).

## Timing
- Reset (rst high at an edge) sets the following:
  - state IDLE;
  - GNT=0, S2=S1=S0=0, VALID=0, TIMEOUT=0;
  - PTR=0, OWN=0, HCNT=0.
- Reset overrides everything, including an active grant mid-hold. It takes effect at the next edge.
- Grant latency: REQ seen in IDLE at edge N gives GNT/select/VALID valid after edge N, one cycle.
- Release latency: a release condition seen at edge M clears GNT/VALID after edge M.
- The FSM spends at least one IDLE cycle between grants, so the earliest next grant is after edge M+1. This is the dead cycle the mux needs to switch select lines cleanly.
- Timeout: with MAX_HOLD=k, a continuously requesting owner holds VALID for exactly k cycles.
- Select lines change only on the IDLE-to-GRANT edge. They never change while VALID=1.

## Test plan
- **Reset, single request:**
  - Stimulus: hold rst for 2 cycles, then REQ=8'h01 and DONE=0.
  - Required: GNT=8'h01, S=000, VALID=1 one cycle later. With MAX_HOLD=16, TIMEOUT pulses and VALID falls after 16 VALID cycles.
- **Round-robin rotation:**
  - Stimulus: REQ=8'hFF held, DONE pulsed one cycle after each grant.
  - Required: GNT sequence 01,02,04,...,80,01, with S counting 000..111, and VALID low for one cycle between each grant.
- **Pointer wrap:**
  - Stimulus: after granting index 6 and releasing, present REQ=8'h41.
  - Required: index 0 is granted (S=000), not index 6, because PTR=7 and the search wraps.
- **Request drop and ignored non-owner:**
  - Stimulus: owner is index 3 (S=011), REQ=8'h88; then REQ[3] is deasserted.
  - Required: index 7 is not granted while index 3 holds. After the drop, VALID=0 for one cycle, then GNT=8'h80, S=111.
- **Simultaneous DONE and timeout:**
  - Stimulus: MAX_HOLD=4, DONE asserted in the 4th hold cycle.
  - Required: release occurs with TIMEOUT=0. With DONE absent in the same setup, TIMEOUT=1 for exactly one cycle.
- **Reset mid-grant:**
  - Stimulus: rst asserted while GNT=8'h20.
  - Required: GNT=0, S=000, VALID=0 after the edge. With REQ=8'h20 still present after rst drops, index 5 is granted again.

Source files
------------

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
//   REQ     : per-requester request vector (bit i -> mux input i, 0=A .. 7=H)
//   DONE    : owner release strobe
//   GNT     : one-hot grant, zero when idle
//   S2..S0  : mux select lines for the granted input
//   VALID   : a grant is active and the mux output is meaningful
//   TIMEOUT : one-cycle pulse when a grant is revoked by the hold limit
// master = requester side, slave = arbiter side.
interface mux8_rr_arbiter_if;
  logic [7:0] REQ;
  logic       DONE;
  logic [7:0] GNT;
  logic       S2;
  logic       S1;
  logic       S0;
  logic       VALID;
  logic       TIMEOUT;

  modport master (
    output REQ,
    output DONE,
    input  GNT,
    input  S2,
    input  S1,
    input  S0,
    input  VALID,
    input  TIMEOUT
  );

  modport slave (
    input  REQ,
    input  DONE,
    output GNT,
    output S2,
    output S1,
    output S0,
    output VALID,
    output TIMEOUT
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin scheduler for an 8:1 mux. Grants one requester at a time,
// drives the mux select lines for the owner, and rotates priority after
// each release so no requester starves.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of mux8_rr_arbiter_if (REQ/DONE in; GNT/S2..S0/VALID/TIMEOUT out)
// MAX_HOLD bounds how many cycles a grant may be held (0 = unlimited, 0..255).
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mux8_rr_arbiter_if.slave      bus
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 8;
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   own;
  logic [CNT_W-1:0]   hcnt;
  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   sel;
  logic               valid;
  logic               timeout;

  // Output wiring; every output is a register below.
  assign bus.GNT     = gnt;
  assign bus.S2      = sel[2];
  assign bus.S1      = sel[1];
  assign bus.S0      = sel[0];
  assign bus.VALID   = valid;
  assign bus.TIMEOUT = timeout;

  // First requester at or after ptr, searching upward with wrap. The loop
  // runs from the farthest offset to the nearest so the nearest wins.
  logic [IDX_W-1:0] pick_idx;
  logic             pick_hit;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_idx = ptr;
    pick_hit = 1'b0;
    cand     = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (bus.REQ[cand]) begin
        pick_idx = cand;
        pick_hit = 1'b1;
      end
    end
  end

  // Release causes while holding a grant.
  logic owner_req;
  logic hold_expired;
  logic release_now;
  logic timeout_only;

  always_comb begin
    owner_req    = bus.REQ[own];
    hold_expired = HOLD_EN && (hcnt == HOLD_LAST);
    release_now  = bus.DONE || !owner_req || hold_expired;
    // Timeout is flagged only when nothing else would have released.
    timeout_only = hold_expired && !bus.DONE && owner_req;
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      own     <= '0;
      hcnt    <= '0;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_hit) begin
            own   <= pick_idx;
            gnt   <= N_REQ'(1) << pick_idx;
            sel   <= pick_idx;
            valid <= 1'b1;
            hcnt  <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (hcnt != CNT_MAX) begin
            hcnt <= hcnt + CNT_W'(1);
          end
          if (release_now) begin
            gnt     <= '0;
            valid   <= 1'b0;
            ptr     <= own + IDX_W'(1);
            timeout <= timeout_only;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
